pm_boot_loader: RTL and testbench

- Upstream of the processor core. Receives a byte stream from a host over a valid/ready handshake and assembles it into PMD_SIZE-bit instruction words.
- Writes each word into program memory through the PM write port, starting at address 0.
- Holds the core (sequencer, DAG, CU) in reset until a load completes with a correct checksum.
- Provides the pmDataIn path that program memory still lacks.

---
 rtl/pm_boot_loader.sv | 183 ++++++++++++++++++
 tb/tb_pm_boot_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_boot_loader.sv
// pm_boot_loader: assembles a host byte stream into program-memory words,
// writes them from address 0 upward, and holds the core in reset until a
// load finishes with a matching checksum.
//
// Handshake: a byte moves on a rising clk edge when host_vld && ld_host_rdy
// are both high. The host holds host_dt stable while host_vld is high and
// ld_host_rdy is low. The loader never drops a presented byte and waits
// indefinitely for host_vld.
module pm_boot_loader #(
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 32,
  parameter int CNT_SIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                host_start,
  input  logic [7:0]          host_dt,
  input  logic                host_vld,
  output logic                ld_host_rdy,
  output logic                ld_pm_cslt,
  output logic                ld_pm_wrb,
  output logic [PMA_SIZE-1:0] ld_pm_add,
  output logic [PMD_SIZE-1:0] ld_pm_dt,
  output logic                ld_core_rst,
  output logic                ld_done,
  output logic                ld_err
);

  localparam int WORD_BYTES = PMD_SIZE / 8;
  localparam int CNT_BYTES  = CNT_SIZE / 8;

  // Byte index compare points. LEN_HI covers every count byte except the
  // last, which is always taken in LEN_LO.
  localparam logic [7:0] WORD_LAST   = 8'(WORD_BYTES - 1);
  localparam logic [7:0] CNT_PENULT  = 8'(CNT_BYTES - 2);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  // A one-byte count field has no high part, so the load starts in LEN_LO.
  localparam state_t FIRST_LEN = (CNT_BYTES > 1) ? LEN_HI : LEN_LO;

  state_t                state;
  state_t                state_nxt;
  logic [7:0]            byte_idx;
  logic [CNT_SIZE-1:0]   cnt_reg;
  logic [PMD_SIZE-1:0]   word_reg;
  logic [PMA_SIZE-1:0]   addr_reg;
  logic [7:0]            sum_reg;

  logic                  accept;
  logic                  start_ok;
  logic [CNT_SIZE-1:0]   cnt_shift;
  logic [PMD_SIZE-1:0]   word_shift;

  assign accept     = host_vld && ld_host_rdy;
  assign start_ok   = host_start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign cnt_shift  = (cnt_reg << 8) | CNT_SIZE'(host_dt);
  assign word_shift = (word_reg << 8) | PMD_SIZE'(host_dt);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (host_start) state_nxt = FIRST_LEN;
      end
      LEN_HI: begin
        if (accept && (byte_idx == CNT_PENULT)) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (accept) state_nxt = (cnt_shift == '0) ? CSUM : DATA;
      end
      DATA: begin
        if (accept && (byte_idx == WORD_LAST)) state_nxt = WRITE;
      end
      WRITE: begin
        // cnt_reg still holds the count before this write is retired.
        state_nxt = (cnt_reg == CNT_SIZE'(1)) ? CSUM : DATA;
      end
      CSUM: begin
        if (accept) state_nxt = (host_dt == sum_reg) ? DONE : ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; every output is a function of the current state and
  // registered datapath only.
  always_comb begin
    ld_host_rdy = 1'b0;
    ld_pm_cslt  = 1'b0;
    ld_pm_wrb   = 1'b0;
    ld_pm_add   = addr_reg;
    ld_pm_dt    = '0;
    ld_core_rst = 1'b1;
    ld_done     = 1'b0;
    ld_err      = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA, CSUM: ld_host_rdy = 1'b1;
      WRITE: begin
        ld_pm_cslt = 1'b1;
        ld_pm_wrb  = 1'b1;
        ld_pm_dt   = word_reg;
      end
      DONE: begin
        ld_done     = 1'b1;
        ld_core_rst = 1'b0;
      end
      ERR: ld_err = 1'b1;
      default: ;
    endcase
  end

  // Datapath: count/word shift registers, byte index, address and checksum.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx <= '0;
      cnt_reg  <= '0;
      word_reg <= '0;
      addr_reg <= '0;
      sum_reg  <= '0;
    end else if (start_ok) begin
      byte_idx <= '0;
      cnt_reg  <= '0;
      word_reg <= '0;
      addr_reg <= '0;
      sum_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          addr_reg <= '0;
          sum_reg  <= '0;
        end
        LEN_HI: begin
          if (accept) begin
            cnt_reg  <= cnt_shift;
            sum_reg  <= sum_reg + host_dt;
            byte_idx <= byte_idx + 8'd1;
          end
        end
        LEN_LO: begin
          if (accept) begin
            cnt_reg  <= cnt_shift;
            sum_reg  <= sum_reg + host_dt;
            byte_idx <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            word_reg <= word_shift;
            sum_reg  <= sum_reg + host_dt;
            byte_idx <= (byte_idx == WORD_LAST) ? 8'd0 : byte_idx + 8'd1;
          end
        end
        WRITE: begin
          // Address wraps naturally at 2^PMA_SIZE.
          addr_reg <= addr_reg + PMA_SIZE'(1);
          cnt_reg  <= cnt_reg - CNT_SIZE'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_boot_loader.sv
// Bench for pm_boot_loader: table of directed loads, hand-written reset and
// restart sequences, then randomized loads built from the stream format.
module tb_pm_boot_loader;

  localparam int PMA = 16;
  localparam int PMD = 32;
  localparam int CNT = 16;

  logic           clk;
  logic           reset;
  logic           host_start;
  logic [7:0]     host_dt;
  logic           host_vld;
  logic           ld_host_rdy;
  logic           ld_pm_cslt;
  logic           ld_pm_wrb;
  logic [PMA-1:0] ld_pm_add;
  logic [PMD-1:0] ld_pm_dt;
  logic           ld_core_rst;
  logic           ld_done;
  logic           ld_err;

  int n_cmp = 0;
  int n_bad = 0;

  // expected PM writes: {address, data}
  logic [PMA+PMD-1:0] exp_q[$];

  pm_boot_loader #(.PMA_SIZE(PMA), .PMD_SIZE(PMD), .CNT_SIZE(CNT)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_start  (host_start),
    .host_dt     (host_dt),
    .host_vld    (host_vld),
    .ld_host_rdy (ld_host_rdy),
    .ld_pm_cslt  (ld_pm_cslt),
    .ld_pm_wrb   (ld_pm_wrb),
    .ld_pm_add   (ld_pm_add),
    .ld_pm_dt    (ld_pm_dt),
    .ld_core_rst (ld_core_rst),
    .ld_done     (ld_done),
    .ld_err      (ld_err)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every write pulse must match the head of exp_q
  always @(negedge clk) begin
    if (ld_pm_cslt || ld_pm_wrb) begin
      check("wrb_with_cslt", {ld_pm_cslt, ld_pm_wrb}, 2'b11);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {ld_pm_add, ld_pm_dt}, '0);
        n_cmp--;
        if ({ld_pm_add, ld_pm_dt} === '0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got write @0 of 0 expected none");
        end else begin
          n_cmp++;
        end
      end else begin
        check("pm_write", {ld_pm_add, ld_pm_dt}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},   ld_host_rdy, 0);
    check({tag, "_cslt"},  ld_pm_cslt, 0);
    check({tag, "_wrb"},   ld_pm_wrb, 0);
    check({tag, "_add"},   ld_pm_add, 0);
    check({tag, "_dt"},    ld_pm_dt, 0);
    check({tag, "_crst"},  ld_core_rst, 1);
    check({tag, "_done"},  ld_done, 0);
    check({tag, "_err"},   ld_err, 0);
  endtask

  task automatic do_start();
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    check("start_core_rst", ld_core_rst, 1);
    check("start_done_clr", ld_done, 0);
    check("start_err_clr",  ld_err, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit is_last);
    int g;
    int t;
    g = 0;
    while (g < 8 && int'($urandom_range(0, 99)) < gap_pct) begin
      host_vld   = 1'b0;
      host_dt    = 8'($urandom);
      host_start = ($urandom_range(0, 4) == 0);  // must be ignored mid-load
      @(negedge clk);
      g++;
    end
    host_start = 1'b0;
    host_vld   = 1'b1;
    host_dt    = b;
    t = 0;
    while (!ld_host_rdy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!ld_host_rdy) begin
      check("rdy_timeout", 0, 1);
      host_vld = 1'b0;
      return;
    end
    if (is_last) check("core_rst_pre_csum", ld_core_rst, 1);
    @(negedge clk);
    host_vld = 1'b0;
  endtask

  task automatic finish_load(input string tag, input logic e_done, input logic e_err);
    check({tag, "_done"},     ld_done, e_done);
    check({tag, "_err"},      ld_err, e_err);
    check({tag, "_core_rst"}, ld_core_rst, !e_done);
    check({tag, "_pending"},  exp_q.size(), 0);
    exp_q.delete();
  endtask

  // directed vector table
  typedef struct {
    int                len;
    logic [0:11][7:0]  b;
    int                gap;
    int                n_wr;
    logic [1:0][31:0]  wd;
    logic              exp_done;
    logic              exp_err;
  } vec_t;

  vec_t vecs[4];

  // higher-level reference: build a stream from a word list
  logic [7:0] rbytes[$];
  logic [31:0] rwords[$];

  initial begin
    logic [7:0] sum;
    logic [7:0] csum;
    int n;
    bit bad;

    reset = 1'b1; host_start = 1'b0; host_vld = 1'b0; host_dt = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_core_rst", ld_core_rst, 1);

    vecs[0] = '{len: 11, b: {8'h00,8'h02,8'hDE,8'hAD,8'hBE,8'hEF,8'h00,8'h00,8'h00,8'h01,8'h3B,8'h00},
                gap: 0,  n_wr: 2, wd: {32'h00000001, 32'hDEADBEEF}, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{len: 3,  b: {8'h00,8'h00,8'h00, 72'h0},
                gap: 0,  n_wr: 0, wd: '0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{len: 11, b: {8'h00,8'h02,8'hDE,8'hAD,8'hBE,8'hEF,8'h00,8'h00,8'h00,8'h01,8'h3C,8'h00},
                gap: 0,  n_wr: 2, wd: {32'h00000001, 32'hDEADBEEF}, exp_done: 1'b0, exp_err: 1'b1};
    vecs[3] = '{len: 11, b: {8'h00,8'h02,8'hDE,8'hAD,8'hBE,8'hEF,8'h00,8'h00,8'h00,8'h01,8'h3B,8'h00},
                gap: 40, n_wr: 2, wd: {32'h00000001, 32'hDEADBEEF}, exp_done: 1'b1, exp_err: 1'b0};

    for (int v = 0; v < 4; v++) begin
      for (int w = 0; w < vecs[v].n_wr; w++) exp_q.push_back({PMA'(w), vecs[v].wd[w]});
      do_start();
      for (int i = 0; i < vecs[v].len; i++) send_byte(vecs[v].b[i], vecs[v].gap, i == vecs[v].len - 1);
      finish_load($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
      @(negedge clk);
      check($sformatf("vec%0d_hold", v), {ld_done, ld_err}, {vecs[v].exp_done, vecs[v].exp_err});
    end

    // reset in the middle of the first word: nothing written, reset values next cycle
    do_start();
    for (int i = 0; i < 5; i++) send_byte(vecs[0].b[i], 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    @(negedge clk);
    check("midrst_no_write", exp_q.size(), 0);
    exp_q.push_back({PMA'(0), 32'hDEADBEEF});
    exp_q.push_back({PMA'(1), 32'h00000001});
    do_start();
    for (int i = 0; i < 11; i++) send_byte(vecs[0].b[i], 0, i == 10);
    finish_load("after_rst", 1'b1, 1'b0);

    // restart straight from DONE
    exp_q.push_back({PMA'(0), 32'h12345678});
    do_start();
    send_byte(8'h00, 0, 0); send_byte(8'h01, 0, 0);
    send_byte(8'h12, 0, 0); send_byte(8'h34, 0, 0);
    send_byte(8'h56, 0, 0); send_byte(8'h78, 0, 0);
    send_byte(8'h15, 0, 1);
    finish_load("restart", 1'b1, 1'b0);

    // randomized loads against the stream-format model
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 5);
      bad = ($urandom_range(0, 3) == 0);
      rbytes.delete();
      rwords.delete();
      rbytes.push_back(8'(n >> 8));
      rbytes.push_back(8'(n));
      for (int w = 0; w < n; w++) begin
        rwords.push_back($urandom);
        for (int k = 3; k >= 0; k--) rbytes.push_back(8'(rwords[w] >> (8 * k)));
        exp_q.push_back({PMA'(w), rwords[w]});
      end
      sum = 8'h00;
      foreach (rbytes[i]) sum = sum + rbytes[i];
      csum = bad ? sum ^ 8'($urandom_range(1, 255)) : sum;
      rbytes.push_back(csum);
      do_start();
      foreach (rbytes[i]) send_byte(rbytes[i], $urandom_range(0, 50), i == rbytes.size() - 1);
      finish_load($sformatf("rnd%0d", r), !bad, bad);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
